jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shares a bank of WIDTH JK flip-flops between two command requesters. Each requester issues one bit-index plus a JK operation (hold/reset/set/toggle) over a valid/ready handshake. A three-state FSM with round-robin fairness applies exactly one command per transaction to exactly one cell. The block is the sequencing layer above the JK flip-flop primitive and exposes the full bank state as q/qbar.

## Interface
Parameters:
- WIDTH, 4, number of JK cells in the bank (≥2)
- IW, $clog2(WIDTH) (minimum 1), index width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 command valid; held with payload stable until req0_ready
- req0_idx  in  IW  target cell index
- req0_jk  in  2  operation; bit1 = J, bit0 = K
- req0_ready  out  1  one-cycle completion pulse for requester 0
- req1_valid, req1_idx, req1_jk, req1_ready  same as requester 0, for requester 1
- grant_id  out  1  requester owning the current/last transaction
- q  out  WIDTH  bank state
- qbar  out  WIDTH  bitwise complement of q, always
- err  out  1  present only with JKARB_ERR_EN; one-cycle pulse, aligned with ready

## Operation
- JK encoding: 00 hold, 01 reset (q=0), 10 set (q=1), 11 toggle.
- States:
  - IDLE: if any valid, grant, latch idx/jk, go to EXEC; else stay.
  - EXEC: drive latched jk to cell idx, 00 to all other cells; go to RESP.
  - RESP: assert the granted requester's ready; flip last-granted; go to IDLE.
- Arbitration:
  - Single valid: granted.
  - Both valid: grant the requester that was not last granted.
  - last-granted resets to 1, so req0 wins first.
- Valid is sampled only in IDLE. Dropping valid during EXEC/RESP has no effect; the command still completes.
- Ready is never asserted outside RESP, and only for grant_id.
- Out-of-range idx (idx ≥ WIDTH):
  - Handshake completes.
  - No cell changes.
- Reset values: q=0, qbar=all 1, req0_ready=req1_ready=0, grant_id=0, err=0, state IDLE, last-granted=1.
- Reset mid-transaction (any state) aborts:
  - No ready pulse.
  - Bank cleared.
  - After release, a still-valid requester is re-served from IDLE.

## Timing
- Edge N: IDLE samples valid, latches command, grant_id updates.
- Edge N+1: target cell updates; the new q is visible after N+1.
- Cycle between N+1 and N+2: ready (and err) high; the requester samples it at edge N+2.
- Throughput: one command per 3 cycles. Latency valid→ready: 2 edges.
- Back-to-back: a requester may present its next command in the cycle after ready. It is granted at the next IDLE edge, subject to round-robin.
- A requester that keeps valid high continuously alternates with the other requester when both are active.
- q/qbar are registered outputs. Ready, grant_id and err are decoded from registered state only, with no input→output combinational path.

## Configuration
- JKARB_ERR_EN defined:
  - err port and range check exist.
  - err pulses with ready for idx ≥ WIDTH.
- JKARB_ERR_EN undefined:
  - No err port.
  - Out-of-range commands complete silently with no effect.
  - All other behaviour is identical.

## Structure
- Package jkarb_pkg:
  - State enum: IDLE, EXEC, RESP.
  - JK constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
- Sub-module jk_cell:
  - One JK flip-flop with clk, rst (async, active-low), jk[1:0], q, qbar.
  - Reset value q=0.
  - Instantiated WIDTH times via generate.
- The arbiter FSM, latches and decode stay in jk_bank_arbiter.

## Test plan
- Reset (WIDTH=4): assert rst low mid-clock → immediately q=0000, qbar=1111, both ready=0, grant_id=0.
- req0 set idx2 (jk=10) → q=0100 after edge N+1; req0_ready high exactly one cycle; req1_ready stays 0.
- Both valid from reset: req0 reset idx1, req1 set idx1 → req0 served first (q[1]=0), then req1 (q[1]=1), then req0 again; grant_id sequence 0,1,0.
- Toggle and hold on idx0:
  - Toggle idx0 twice → q[0]=1 then 0.
  - jk=00 on idx3 → q unchanged, ready still pulses.
- idx=5, WIDTH=8 vs idx=6, WIDTH=6 with JKARB_ERR_EN:
  - idx=5 with WIDTH=8: normal update, err=0.
  - idx=6 with WIDTH=6: q unchanged, err pulses with ready.
- Reset mid-transaction: drop rst during EXEC → no ready pulse, q=0. Release rst with req1_valid held → req1 served from IDLE within 2 edges.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types and JK operation encodings for the JK bank arbiter.
// Optional feature macro used across the slice: JKARB_ERR_EN.
package jkarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Next value of one JK cell given its operation and present state.
  function automatic logic jk_apply(input logic [1:0] jk, input logic q);
    logic r;
    r = q;
    case (jk)
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester command bus plus bank state for the JK bank arbiter.
// The err member exists only when JKARB_ERR_EN is defined.
interface jkarb_if #(
  parameter int WIDTH = 4
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic            req0_valid;
  logic [IW-1:0]   req0_idx;
  logic [1:0]      req0_jk;
  logic            req0_ready;
  logic            req1_valid;
  logic [IW-1:0]   req1_idx;
  logic [1:0]      req1_jk;
  logic            req1_ready;
  logic            grant_id;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
`ifdef JKARB_ERR_EN
  logic            err;
`endif

  modport master (
    output req0_valid, req0_idx, req0_jk,
    output req1_valid, req1_idx, req1_jk,
    input  req0_ready, req1_ready, grant_id, q, qbar
`ifdef JKARB_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  req0_valid, req0_idx, req0_jk,
    input  req1_valid, req1_idx, req1_jk,
    output req0_ready, req1_ready, grant_id, q, qbar
`ifdef JKARB_ERR_EN
    , output err
`endif
  );

endinterface

// File: rtl/jk_bank_arbiter_jk_cell.sv
// Single JK flip-flop cell; asynchronous active-low reset clears q.
module jk_cell
  import jkarb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] jk,
  output logic       q,
  output logic       qbar
);

  logic q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= jk_apply(jk, q_reg);
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin IDLE/EXEC/RESP sequencer applying one JK command per transaction
// to a bank of WIDTH jk_cell instances. JKARB_ERR_EN adds the out-of-range err pulse.
module jk_bank_arbiter
  import jkarb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  jkarb_if.slave   bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW:0] WIDTH_W = (IW + 1)'(WIDTH);

  state_t        state_reg, state_next;
  logic          last_reg, last_next;
  logic          grant_reg, grant_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [1:0]    jk_reg, jk_next;
  logic          pick;
  logic          in_range;
  logic [WIDTH-1:0] cell_sel;
  logic [WIDTH-1:0] q_bank;
  logic [WIDTH-1:0] qbar_bank;

  // last_reg resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      grant_reg <= 1'b0;
      idx_reg   <= '0;
      jk_reg    <= JK_HOLD;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      jk_reg    <= jk_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    jk_next    = jk_reg;
    pick       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          if (bus.req0_valid && bus.req1_valid) begin
            pick = ~last_reg;
          end else begin
            pick = bus.req1_valid;
          end
          grant_next = pick;
          idx_next   = pick ? bus.req1_idx : bus.req0_idx;
          jk_next    = pick ? bus.req1_jk  : bus.req0_jk;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        last_next  = grant_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_range = ({1'b0, idx_reg} < WIDTH_W);

  // Only the addressed cell sees the latched op during EXEC; all others hold.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign cell_sel[gi] = (state_reg == EXEC) && in_range && (idx_reg == IW'(gi));
      jk_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .jk   (cell_sel[gi] ? jk_reg : JK_HOLD),
        .q    (q_bank[gi]),
        .qbar (qbar_bank[gi])
      );
    end
  endgenerate

  assign bus.q          = q_bank;
  assign bus.qbar       = qbar_bank;
  assign bus.grant_id   = grant_reg;
  assign bus.req0_ready = (state_reg == RESP) && !grant_reg;
  assign bus.req1_ready = (state_reg == RESP) && grant_reg;
`ifdef JKARB_ERR_EN
  assign bus.err        = (state_reg == RESP) && !in_range;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (WIDTH 4, 8 and 6 instances).
// err checks are compiled in only when JKARB_ERR_EN is defined.
module tb_jk_bank_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jkarb_if #(.WIDTH(4)) bif ();
  jkarb_if #(.WIDTH(8)) bif8 ();
  jkarb_if #(.WIDTH(6)) bif6 ();

  jk_bank_arbiter #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(bif));
  jk_bank_arbiter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bif8));
  jk_bank_arbiter #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .bus(bif6));

  always #5 clk = ~clk;

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bif.q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b exp 0000", bif.q); end
    checks++; if (bif.qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got %b exp 1111", bif.qbar); end
    checks++; if (bif.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_r0 got %b exp 0", bif.req0_ready); end
    checks++; if (bif.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_r1 got %b exp 0", bif.req1_ready); end
    checks++; if (bif.grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant got %b exp 0", bif.grant_id); end
`ifdef JKARB_ERR_EN
    checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bif.err); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    $display("txn reset q=%b qbar=%b", bif.q, bif.qbar);
  endtask

  task automatic test_set();
    @(negedge clk);
    bif.req0_valid = 1'b1; bif.req0_idx = 2'd2; bif.req0_jk = 2'b10;
    @(posedge clk); #1;
    checks++; if (bif.grant_id !== 1'b0) begin errors++; $display("FAIL set_grant got %b exp 0", bif.grant_id); end
    checks++; if (bif.q !== 4'b0000) begin errors++; $display("FAIL set_q_early got %b exp 0000", bif.q); end
    checks++; if (bif.req0_ready !== 1'b0) begin errors++; $display("FAIL set_r0_early got %b exp 0", bif.req0_ready); end
    @(posedge clk); #1;
    checks++; if (bif.q !== 4'b0100) begin errors++; $display("FAIL set_q got %b exp 0100", bif.q); end
    checks++; if (bif.qbar !== 4'b1011) begin errors++; $display("FAIL set_qbar got %b exp 1011", bif.qbar); end
    checks++; if (bif.req0_ready !== 1'b1) begin errors++; $display("FAIL set_r0 got %b exp 1", bif.req0_ready); end
    checks++; if (bif.req1_ready !== 1'b0) begin errors++; $display("FAIL set_r1 got %b exp 0", bif.req1_ready); end
    @(posedge clk); #1;
    checks++; if (bif.req0_ready !== 1'b0) begin errors++; $display("FAIL set_r0_pulse got %b exp 0", bif.req0_ready); end
    bif.req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0) begin errors++; $display("FAIL set_idle_ready got %b%b exp 00", bif.req0_ready, bif.req1_ready); end
      checks++; if (bif.q !== 4'b0100) begin errors++; $display("FAIL set_idle_q got %b exp 0100", bif.q); end
    end
    $display("txn req0 set idx2 q=%b", bif.q);
  endtask

  task automatic test_both();
    logic exp_g  [3] = '{1'b0, 1'b1, 1'b0};
    logic exp_q1 [3] = '{1'b0, 1'b1, 1'b0};
    reset_all();
    @(negedge clk);
    bif.req0_valid = 1'b1; bif.req0_idx = 2'd1; bif.req0_jk = 2'b01;
    bif.req1_valid = 1'b1; bif.req1_idx = 2'd1; bif.req1_jk = 2'b10;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      checks++; if (bif.grant_id !== exp_g[t]) begin errors++; $display("FAIL both_grant[%0d] got %b exp %b", t, bif.grant_id, exp_g[t]); end
      @(posedge clk); #1;
      checks++; if (bif.q[1] !== exp_q1[t]) begin errors++; $display("FAIL both_q1[%0d] got %b exp %b", t, bif.q[1], exp_q1[t]); end
      checks++; if (bif.req0_ready !== !exp_g[t] || bif.req1_ready !== exp_g[t]) begin
        errors++; $display("FAIL both_ready[%0d] got r0=%b r1=%b exp r0=%b r1=%b", t, bif.req0_ready, bif.req1_ready, !exp_g[t], exp_g[t]);
      end
      @(posedge clk); #1;
      checks++; if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0) begin errors++; $display("FAIL both_ready_low[%0d] got %b%b exp 00", t, bif.req0_ready, bif.req1_ready); end
      $display("txn both round %0d grant=%b q=%b", t, bif.grant_id, bif.q);
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
  endtask

  task automatic test_toggle_hold();
    logic [1:0] c_idx [4] = '{2'd0, 2'd0, 2'd3, 2'd0};
    logic [1:0] c_jk  [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
    logic [3:0] c_q   [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    for (int t = 0; t < 4; t++) begin
      bif.req0_valid = 1'b1; bif.req0_idx = c_idx[t]; bif.req0_jk = c_jk[t];
      @(posedge clk); #1;
      checks++; if (bif.grant_id !== 1'b0) begin errors++; $display("FAIL th_grant[%0d] got %b exp 0", t, bif.grant_id); end
      @(posedge clk); #1;
      checks++; if (bif.q !== c_q[t]) begin errors++; $display("FAIL th_q[%0d] got %b exp %b", t, bif.q, c_q[t]); end
      checks++; if (bif.qbar !== ~c_q[t]) begin errors++; $display("FAIL th_qbar[%0d] got %b exp %b", t, bif.qbar, ~c_q[t]); end
      checks++; if (bif.req0_ready !== 1'b1) begin errors++; $display("FAIL th_r0[%0d] got %b exp 1", t, bif.req0_ready); end
      @(posedge clk); #1;
      checks++; if (bif.req0_ready !== 1'b0) begin errors++; $display("FAIL th_r0_low[%0d] got %b exp 0", t, bif.req0_ready); end
      $display("txn req0 idx%0d jk=%b q=%b", c_idx[t], c_jk[t], bif.q);
    end
    bif.req0_valid = 1'b0;
  endtask

  task automatic test_range();
    logic [2:0] i8  [3] = '{3'd5, 3'd7, 3'd0};
    logic [1:0] j8  [3] = '{2'b10, 2'b10, 2'b11};
    logic [7:0] q8  [3] = '{8'h20, 8'hA0, 8'hA1};
    logic [2:0] i6  [3] = '{3'd6, 3'd5, 3'd7};
    logic [1:0] j6  [3] = '{2'b10, 2'b10, 2'b11};
    logic [5:0] q6  [3] = '{6'h00, 6'h20, 6'h20};
    logic       e6  [3] = '{1'b1, 1'b0, 1'b1};
    reset_all();
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      bif8.req0_valid = 1'b1; bif8.req0_idx = i8[t]; bif8.req0_jk = j8[t];
      bif6.req0_valid = 1'b1; bif6.req0_idx = i6[t]; bif6.req0_jk = j6[t];
      @(posedge clk); #1;
`ifdef JKARB_ERR_EN
      checks++; if (bif6.err !== 1'b0) begin errors++; $display("FAIL rng_err6_exec[%0d] got %b exp 0", t, bif6.err); end
`endif
      @(posedge clk); #1;
      checks++; if (bif8.q !== q8[t]) begin errors++; $display("FAIL rng_q8[%0d] got %h exp %h", t, bif8.q, q8[t]); end
      checks++; if (bif6.q !== q6[t]) begin errors++; $display("FAIL rng_q6[%0d] got %h exp %h", t, bif6.q, q6[t]); end
      checks++; if (bif6.qbar !== ~q6[t]) begin errors++; $display("FAIL rng_qbar6[%0d] got %h exp %h", t, bif6.qbar, ~q6[t]); end
      checks++; if (bif8.req0_ready !== 1'b1 || bif6.req0_ready !== 1'b1) begin errors++; $display("FAIL rng_ready[%0d] got %b%b exp 11", t, bif8.req0_ready, bif6.req0_ready); end
`ifdef JKARB_ERR_EN
      checks++; if (bif8.err !== 1'b0) begin errors++; $display("FAIL rng_err8[%0d] got %b exp 0", t, bif8.err); end
      checks++; if (bif6.err !== e6[t]) begin errors++; $display("FAIL rng_err6[%0d] got %b exp %b", t, bif6.err, e6[t]); end
`endif
      @(posedge clk); #1;
      checks++; if (bif6.req0_ready !== 1'b0) begin errors++; $display("FAIL rng_ready_low[%0d] got %b exp 0", t, bif6.req0_ready); end
`ifdef JKARB_ERR_EN
      checks++; if (bif6.err !== 1'b0) begin errors++; $display("FAIL rng_err6_low[%0d] got %b exp 0", t, bif6.err); end
`endif
      $display("txn range w8 idx%0d q=%h | w6 idx%0d q=%h oor=%b", i8[t], bif8.q, i6[t], bif6.q, e6[t]);
    end
    bif8.req0_valid = 1'b0;
    bif6.req0_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bif.req0_valid = 1'b1; bif.req0_idx = 2'd3; bif.req0_jk = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.q !== 4'b1000) begin errors++; $display("FAIL mid_pre_q got %b exp 1000", bif.q); end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b1; bif.req1_idx = 2'd2; bif.req1_jk = 2'b10;
    @(posedge clk); #1;
    checks++; if (bif.grant_id !== 1'b1) begin errors++; $display("FAIL mid_grant got %b exp 1", bif.grant_id); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bif.q !== 4'b0000) begin errors++; $display("FAIL mid_q got %b exp 0000", bif.q); end
    checks++; if (bif.qbar !== 4'b1111) begin errors++; $display("FAIL mid_qbar got %b exp 1111", bif.qbar); end
    checks++; if (bif.grant_id !== 1'b0) begin errors++; $display("FAIL mid_grant_rst got %b exp 0", bif.grant_id); end
    @(posedge clk); #1;
    checks++; if (bif.req1_ready !== 1'b0) begin errors++; $display("FAIL mid_r1_abort got %b exp 0", bif.req1_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bif.grant_id !== 1'b1) begin errors++; $display("FAIL mid_regrant got %b exp 1", bif.grant_id); end
    checks++; if (bif.req1_ready !== 1'b0) begin errors++; $display("FAIL mid_r1_early got %b exp 0", bif.req1_ready); end
    @(posedge clk); #1;
    checks++; if (bif.q !== 4'b0100) begin errors++; $display("FAIL mid_q_served got %b exp 0100", bif.q); end
    checks++; if (bif.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_r1 got %b exp 1", bif.req1_ready); end
    @(posedge clk); #1;
    bif.req1_valid = 1'b0;
    $display("txn reset mid-exec then req1 set idx2 q=%b", bif.q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bif.req0_valid = 1'b0;  bif.req0_idx = '0;  bif.req0_jk = 2'b00;
    bif.req1_valid = 1'b0;  bif.req1_idx = '0;  bif.req1_jk = 2'b00;
    bif8.req0_valid = 1'b0; bif8.req0_idx = '0; bif8.req0_jk = 2'b00;
    bif8.req1_valid = 1'b0; bif8.req1_idx = '0; bif8.req1_jk = 2'b00;
    bif6.req0_valid = 1'b0; bif6.req0_idx = '0; bif6.req0_jk = 2'b00;
    bif6.req1_valid = 1'b0; bif6.req1_idx = '0; bif6.req1_jk = 2'b00;
    test_reset();
    test_set();
    test_both();
    test_toggle_hold();
    test_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
